spi_transmit_status: RTL and testbench

//  SPI peripheral-side transmitter: FPGA returns a status word (game state, scores) to the MCU on sdo.

---
 rtl/spi_pkg.sv | 17 +
 rtl/sync_edge.sv | 30 +++
 rtl/spi_transmit_status.sv | 148 ++++++++++++++
 tb/tb_spi_transmit_status.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI link types and constants
package spi_pkg;

  localparam int SPI_WIDTH = 16;

  typedef struct packed {
    logic [3:0] game_state;
    logic [5:0] p1_score;
    logic [5:0] p2_score;
  } status_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - synchronizer for an asynchronous input with rise/fall pulses
module sync_edge #(
  parameter int SYNC_FF = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_FF-1:0] sync_q;
  logic               prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_FF-2:0], async_i};
      prev_q <= sync_q[SYNC_FF-1];
    end
  end

  assign level_o = sync_q[SYNC_FF-1];
  assign rise_o  = sync_q[SYNC_FF-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_FF-1] & prev_q;

endmodule

// File: rtl/spi_transmit_status.sv
// rtl/spi_transmit_status.sv - SPI mode-0 peripheral transmitter returning a status word
// Holding register with valid/ready, one snapshot per load frame, MSB first on sdo.
module spi_transmit_status
  import spi_pkg::*;
#(
  parameter int WIDTH   = SPI_WIDTH,
  parameter int SYNC_FF = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sck_i,
  input  logic             load_i,
  output logic             sdo_o,
  input  logic [WIDTH-1:0] status_data_i,
  input  logic             status_valid_i,
  output logic             status_ready_o,
  output logic             frame_done_o,
  output logic             frame_error_o,
  output logic             stale_o
);

  localparam int CNT_W  = $clog2(WIDTH + 2);
  localparam int SET_W  = $clog2(SYNC_FF + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
  localparam logic [SET_W-1:0] SETTLED  = SET_W'(SYNC_FF + 1);

  logic sck_level_unused, sck_rise, sck_fall;
  logic load_level, load_rise, load_fall;

  sync_edge #(.SYNC_FF(SYNC_FF)) u_sck_sync (
    .clk_i(clk_i), .rst_i(rst_i), .async_i(sck_i),
    .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  sync_edge #(.SYNC_FF(SYNC_FF)) u_load_sync (
    .clk_i(clk_i), .rst_i(rst_i), .async_i(load_i),
    .level_o(load_level), .rise_o(load_rise), .fall_o(load_fall)
  );

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d, shift_q, shift_d, last_sent_q, last_sent_d;
  logic             hold_full_q, hold_full_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             armed_q, armed_d;
  logic             sdo_q, sdo_d, stale_q, stale_d, done_q, done_d, err_q, err_d;
  logic             start_frame, end_frame, cnt_en, shift_en, accept;
  logic [WIDTH-1:0] word_sel;

  // Synced load reads low for the first SYNC_FF+1 cycles after reset regardless of the pin,
  // so arming waits for the chain to flush before trusting a low level.
  always_comb begin
    settle_d = (settle_q == SETTLED) ? settle_q : settle_q + 1'b1;
    armed_d  = armed_q | ((settle_q == SETTLED) & ~load_level);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_frame) state_d = ST_SHIFT;
      ST_SHIFT: if (end_frame)   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A frame start swallows any sck edge landing on the same cycle.
  always_comb begin
    start_frame = armed_q & load_rise;
    end_frame   = armed_q & load_fall & (state_q == ST_SHIFT);
    cnt_en      = (state_q == ST_SHIFT) & ~start_frame & ~end_frame & sck_rise;
    shift_en    = (state_q == ST_SHIFT) & ~start_frame & ~end_frame & sck_fall;
  end

  assign accept   = status_valid_i & ~hold_full_q;
  assign word_sel = hold_full_q ? hold_q : last_sent_q;

  always_comb begin
    hold_d      = accept ? status_data_i : hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    last_sent_d = last_sent_q;
    bit_cnt_d   = bit_cnt_q;
    sdo_d       = sdo_q;
    stale_d     = stale_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    if (start_frame) begin
      shift_d     = word_sel;
      last_sent_d = word_sel;
      hold_full_d = 1'b0;
      stale_d     = ~hold_full_q;
      bit_cnt_d   = '0;
      sdo_d       = word_sel[WIDTH-1];
    end else if (end_frame) begin
      sdo_d  = 1'b0;
      done_d = (bit_cnt_q == CNT_FULL);
      err_d  = (bit_cnt_q != CNT_FULL);
    end else begin
      if (cnt_en && bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
      if (shift_en) begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        sdo_d   = shift_q[WIDTH-2];
      end
    end
    if (accept) hold_full_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      last_sent_q <= '0;
      bit_cnt_q   <= '0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      sdo_q       <= 1'b0;
      stale_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      last_sent_q <= last_sent_d;
      bit_cnt_q   <= bit_cnt_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      sdo_q       <= sdo_d;
      stale_q     <= stale_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign sdo_o          = sdo_q;
  assign status_ready_o = ~hold_full_q;
  assign frame_done_o   = done_q;
  assign frame_error_o  = err_q;
  assign stale_o        = stale_q;

endmodule

// File: tb/tb_spi_transmit_status.sv
// tb/tb_spi_transmit_status.sv - directed self-checking bench for spi_transmit_status
module tb_spi_transmit_status;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        load = 1'b0;
  logic [15:0] sdata = '0;
  logic        svalid = 1'b0;
  logic        sdo, status_ready, frame_done, frame_error, stale;

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          d0, e0, k;
  logic [31:0] rx;

  spi_transmit_status #(.WIDTH(16), .SYNC_FF(2)) dut (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .load_i(load), .sdo_o(sdo),
    .status_data_i(sdata), .status_valid_i(svalid), .status_ready_o(status_ready),
    .frame_done_o(frame_done), .frame_error_o(frame_error), .stale_o(stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done)  done_cnt++;
    if (frame_error) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] w);
    int t;
    t = 0;
    @(negedge clk);
    sdata  = w;
    svalid = 1'b1;
    while (!status_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    svalid = 1'b0;
    check("push_accepted", 32'(t < 100), 32'd1);
  endtask

  // MCU model: samples sdo just before each rising sck, shifts out on falling sck.
  task automatic sck_clocks(input int n);
    for (int i = 0; i < n; i++) begin
      rx  = {rx[30:0], sdo};
      sck = 1'b1;
      wait_neg(HALF);
      sck = 1'b0;
      wait_neg(HALF);
    end
  endtask

  task automatic frame(input int n);
    rx = '0;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    load = 1'b1;
    wait_neg(HALF);
    sck_clocks(n);
    load = 1'b0;
    wait_neg(HALF);
  endtask

  initial begin
    wait_neg(3);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_ready", 32'(status_ready), 32'd1);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_error", 32'(frame_error), 32'd0);
    check("rst_stale", 32'(stale), 32'd0);
    rst = 1'b0;
    wait_neg(10);

    // 1: basic frame
    push(16'hA5C3);
    frame(16);
    check("t1_data", rx[15:0], 32'hA5C3);
    check("t1_done", 32'(done_cnt - d0), 32'd1);
    check("t1_err", 32'(err_cnt - e0), 32'd0);
    check("t1_stale", 32'(stale), 32'd0);

    // 2: resend then fresh word
    frame(16);
    check("t2_resend", rx[15:0], 32'hA5C3);
    check("t2_stale", 32'(stale), 32'd1);
    check("t2_done", 32'(done_cnt - d0), 32'd1);
    push(16'h1234);
    frame(16);
    check("t2_fresh", rx[15:0], 32'h1234);
    check("t2_fresh_stale", 32'(stale), 32'd0);

    // 3: back-pressure while holding register is full
    push(16'hBEEF);
    check("t3_full", 32'(status_ready), 32'd0);
    @(negedge clk);
    sdata  = 16'hC0DE;
    svalid = 1'b1;
    wait_neg(4);
    check("t3_held_off", 32'(status_ready), 32'd0);
    load = 1'b1;
    k = 0;
    do begin
      wait_neg(1);
      k++;
    end while (!status_ready && k < 10);
    check("t3_ready_lat", 32'(k), 32'd3);
    wait_neg(1);
    svalid = 1'b0;
    check("t3_second_taken", 32'(status_ready), 32'd0);
    wait_neg(HALF - 4);
    rx = '0;
    d0 = done_cnt;
    sck_clocks(16);
    load = 1'b0;
    wait_neg(HALF);
    check("t3_first", rx[15:0], 32'hBEEF);
    check("t3_done", 32'(done_cnt - d0), 32'd1);
    frame(16);
    check("t3_second", rx[15:0], 32'hC0DE);
    check("t3_stale", 32'(stale), 32'd0);

    // 4: short and long frames
    push(16'h0F0F);
    frame(9);
    check("t4_short_bits", rx[8:0], 32'h01E);
    check("t4_short_err", 32'(err_cnt - e0), 32'd1);
    check("t4_short_done", 32'(done_cnt - d0), 32'd0);
    frame(20);
    check("t4_long_bits", rx[19:0], 32'h0F0F0);
    check("t4_long_err", 32'(err_cnt - e0), 32'd1);
    check("t4_long_done", 32'(done_cnt - d0), 32'd0);
    check("t4_long_stale", 32'(stale), 32'd1);

    // 5: reset mid-frame, released with load still high
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    load = 1'b1;
    wait_neg(HALF);
    sck_clocks(6);
    rst = 1'b1;
    wait_neg(2);
    check("t5_rst_sdo", 32'(sdo), 32'd0);
    check("t5_rst_ready", 32'(status_ready), 32'd1);
    check("t5_rst_stale", 32'(stale), 32'd0);
    rst = 1'b0;
    rx = '0;
    sck_clocks(10);
    check("t5_sdo_quiet", rx[9:0], 32'h0);
    load = 1'b0;
    wait_neg(HALF);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_no_err", 32'(err_cnt - e0), 32'd0);
    push(16'h5A5A);
    frame(16);
    check("t5_new_frame", rx[15:0], 32'h5A5A);
    check("t5_new_done", 32'(done_cnt - d0), 32'd1);
    check("t5_new_stale", 32'(stale), 32'd0);

    // 6: push lands on the capture cycle
    d0 = done_cnt;
    @(negedge clk);
    load = 1'b1;
    wait_neg(2);
    sdata  = 16'h7E81;
    svalid = 1'b1;
    wait_neg(1);
    svalid = 1'b0;
    check("t6_taken", 32'(status_ready), 32'd0);
    wait_neg(HALF - 3);
    rx = '0;
    sck_clocks(16);
    load = 1'b0;
    wait_neg(HALF);
    check("t6_resend", rx[15:0], 32'h5A5A);
    check("t6_stale", 32'(stale), 32'd1);
    check("t6_done", 32'(done_cnt - d0), 32'd1);
    frame(16);
    check("t6_next", rx[15:0], 32'h7E81);
    check("t6_next_stale", 32'(stale), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
